// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline-side bundle for the hazard control unit: hazard sources in,
// per-slot stall/flush controls and performance counters out.
interface hazard_ctrl_unit_if #(
  parameter int STAGES = 5,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic [1:0]        branch_ctrl;
  logic              idex_mem_r;
  logic [REG_AW-1:0] idex_rd;
  logic [REG_AW-1:0] ifid_rs1;
  logic [REG_AW-1:0] ifid_rs2;
  logic              ifid_rs1_use;
  logic              ifid_rs2_use;
  logic              im_req;
  logic              im_ready;
  logic              dm_req;
  logic              dm_ready;
  logic              cnt_clr;
  logic [STAGES-1:0] stall;
  logic [STAGES-1:0] flush;
  logic              err;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output branch_ctrl, idex_mem_r, idex_rd, ifid_rs1, ifid_rs2,
           ifid_rs1_use, ifid_rs2_use, im_req, im_ready, dm_req, dm_ready,
           cnt_clr,
    input  stall, flush, err, stall_cnt, flush_cnt
  );

  modport slave (
    input  branch_ctrl, idex_mem_r, idex_rd, ifid_rs1, ifid_rs2,
           ifid_rs1_use, ifid_rs2_use, im_req, im_ready, dm_req, dm_ready,
           cnt_clr,
    output stall, flush, err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Central pipeline hazard controller: data-memory wait FSM with timeout,
// branch redirect flushing (deferred while stalled), load-use and I-fetch stalls.
module hazard_ctrl_unit #(
  parameter int STAGES         = 5,
  parameter int REG_AW         = 5,
  parameter int BR_FLUSH_DEPTH = 2,
  parameter int TIMEOUT        = 255,
  parameter int CNT_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  hazard_ctrl_unit_if.slave bus
);

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] DM_WAIT = 2'd1;
  localparam logic [1:0] ERR     = 2'd2;

  localparam int WAIT_W = $clog2(TIMEOUT + 2);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  // Redirect squashes slots 1..BR_FLUSH_DEPTH; the PC slot keeps loading the target
  localparam logic [STAGES-1:0] BR_MASK =
    (STAGES'(1) << (BR_FLUSH_DEPTH + 1)) - STAGES'(2);

  logic [1:0]        state, state_nxt;
  logic              pending, pending_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;

  logic              redirect_req;
  logic              load_use;
  logic              im_wait;
  logic              dm_wait_start;
  logic              apply_redirect;

  logic [STAGES-1:0] stall;
  logic [STAGES-1:0] flush;
  logic              err;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  always_comb begin
    redirect_req   = (bus.branch_ctrl != 2'b00);
    load_use       = bus.idex_mem_r && (bus.idex_rd != '0) &&
                     ((bus.ifid_rs1_use && (bus.ifid_rs1 == bus.idex_rd)) ||
                      (bus.ifid_rs2_use && (bus.ifid_rs2 == bus.idex_rd)));
    im_wait        = bus.im_req && !bus.im_ready;
    dm_wait_start  = (state == RUN) && bus.dm_req && !bus.dm_ready;
    apply_redirect = (state == RUN) && !dm_wait_start && (redirect_req || pending);
  end

  always_comb begin
    stall = '0;
    flush = '0;
    err   = 1'b0;
    if (rst) begin
      flush = '1;
    end else begin
      case (state)
        ERR: begin
          stall = '1;
          err   = 1'b1;
        end
        DM_WAIT: begin
          stall = '1;
        end
        RUN: begin
          if (dm_wait_start) begin
            stall = '1;
          end else if (apply_redirect) begin
            flush = BR_MASK;
          end else if (load_use) begin
            stall[1:0] = 2'b11;
            flush[2]   = 1'b1;
          end else if (im_wait) begin
            stall[0] = 1'b1;
            flush[1] = 1'b1;
          end
        end
        default: begin
          stall = '1;
        end
      endcase
    end
  end

  // A redirect suppressed by the entry cycle or by the wait itself is remembered,
  // so the branch target is never lost behind a data-memory stall
  always_comb begin
    state_nxt    = state;
    pending_nxt  = pending;
    wait_cnt_nxt = wait_cnt;
    case (state)
      RUN: begin
        if (dm_wait_start) begin
          state_nxt    = DM_WAIT;
          wait_cnt_nxt = '0;
          pending_nxt  = pending || redirect_req;
        end else if (apply_redirect) begin
          pending_nxt = 1'b0;
        end
      end
      DM_WAIT: begin
        pending_nxt = pending || redirect_req;
        if (bus.dm_ready) begin
          state_nxt = RUN;
        end else if ((TIMEOUT != 0) && (wait_cnt == WAIT_LAST)) begin
          state_nxt = ERR;
        end else begin
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      ERR: begin
        state_nxt = ERR;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      pending  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      pending  <= pending_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall[0] && !(&stall_cnt)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (apply_redirect && !(&flush_cnt)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.stall     = stall;
  assign bus.flush     = flush;
  assign bus.err       = err;
  assign bus.stall_cnt = stall_cnt;
  assign bus.flush_cnt = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: directed scenarios plus random traffic,
// all checked against a cycle-level behavioural model of the hazard rules.
module tb_hazard_ctrl_unit;

  localparam int STAGES  = 5;
  localparam int REG_AW  = 5;
  localparam int BR_D    = 2;
  localparam int TMO     = 4;
  localparam int CW      = 6;
  localparam int CNT_MAX = (1 << CW) - 1;

  typedef struct {
    logic              rst;
    logic [1:0]        br;
    logic              mem_r;
    logic [REG_AW-1:0] idex_rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              rs1_use;
    logic              rs2_use;
    logic              im_req;
    logic              im_ready;
    logic              dm_req;
    logic              dm_ready;
    logic              cnt_clr;
  } stim_t;

  typedef struct {
    logic [STAGES-1:0] stall;
    logic [STAGES-1:0] flush;
    logic              err;
    int                scnt;
    int                fcnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  hazard_ctrl_unit_if #(.STAGES(STAGES), .REG_AW(REG_AW), .CNT_W(CW)) bus ();

  hazard_ctrl_unit #(
    .STAGES(STAGES), .REG_AW(REG_AW), .BR_FLUSH_DEPTH(BR_D),
    .TIMEOUT(TMO), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cycle  = 0;

  // Model state: what the pipeline controller is doing, not how it encodes it
  bit   m_waiting = 0;
  bit   m_failed  = 0;
  bit   m_pending = 0;
  int   m_waited  = 0;
  int   m_scnt    = 0;
  int   m_fcnt    = 0;

  function automatic logic [STAGES-1:0] redirect_flush();
    logic [STAGES-1:0] r;
    r = '0;
    for (int i = 1; i <= BR_D; i++) r[i] = 1'b1;
    return r;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.br = 0; s.mem_r = 0; s.idex_rd = 0; s.rs1 = 0; s.rs2 = 0;
    s.rs1_use = 0; s.rs2_use = 0; s.im_req = 0; s.im_ready = 0;
    s.dm_req = 0; s.dm_ready = 0; s.cnt_clr = 0;
    return s;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cycle);
    end
  endtask

  task automatic model_step(input stim_t s, output exp_t e);
    bit redirected;
    bit hazard;
    redirected = 0;
    e.stall = '0;
    e.flush = '0;
    e.err   = 0;
    e.scnt  = m_scnt;
    e.fcnt  = m_fcnt;
    hazard  = s.mem_r && (s.idex_rd != 0) &&
              ((s.rs1_use && s.rs1 == s.idex_rd) || (s.rs2_use && s.rs2 == s.idex_rd));
    if (s.rst) begin
      e.flush   = '1;
      m_waiting = 0;
      m_failed  = 0;
      m_pending = 0;
      m_waited  = 0;
      m_scnt    = 0;
      m_fcnt    = 0;
    end else begin
      if (m_failed) begin
        e.stall = '1;
        e.err   = 1;
      end else if (m_waiting) begin
        e.stall = '1;
        if (s.br != 0) m_pending = 1;
        if (s.dm_ready) begin
          m_waiting = 0;
        end else begin
          m_waited++;
          if (TMO != 0 && m_waited >= TMO) begin
            m_failed  = 1;
            m_waiting = 0;
          end
        end
      end else if (s.dm_req && !s.dm_ready) begin
        e.stall   = '1;
        m_waiting = 1;
        m_waited  = 0;
        if (s.br != 0) m_pending = 1;
      end else if (s.br != 0 || m_pending) begin
        e.flush    = redirect_flush();
        m_pending  = 0;
        redirected = 1;
      end else if (hazard) begin
        e.stall = 5'b00011;
        e.flush = 5'b00100;
      end else if (s.im_req && !s.im_ready) begin
        e.stall = 5'b00001;
        e.flush = 5'b00010;
      end
      if (s.cnt_clr) begin
        m_scnt = 0;
        m_fcnt = 0;
      end else begin
        if (e.stall[0] && m_scnt < CNT_MAX) m_scnt++;
        if (redirected && m_fcnt < CNT_MAX) m_fcnt++;
      end
    end
  endtask

  task automatic apply_stimulus(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    cycle++;
    rst              = s.rst;
    bus.branch_ctrl  = s.br;
    bus.idex_mem_r   = s.mem_r;
    bus.idex_rd      = s.idex_rd;
    bus.ifid_rs1     = s.rs1;
    bus.ifid_rs2     = s.rs2;
    bus.ifid_rs1_use = s.rs1_use;
    bus.ifid_rs2_use = s.rs2_use;
    bus.im_req       = s.im_req;
    bus.im_ready     = s.im_ready;
    bus.dm_req       = s.dm_req;
    bus.dm_ready     = s.dm_ready;
    bus.cnt_clr      = s.cnt_clr;
    model_step(s, e);
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle the DUT presents a control word, compare it to the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_output("sb_stall",     32'(bus.stall),     32'(e.stall));
        check_output("sb_flush",     32'(bus.flush),     32'(e.flush));
        check_output("sb_err",       32'(bus.err),       32'(e.err));
        check_output("sb_stall_cnt", 32'(bus.stall_cnt), 32'(e.scnt));
        check_output("sb_flush_cnt", 32'(bus.flush_cnt), 32'(e.fcnt));
      end
    end
  end

  initial begin
    stim_t s;
    int    drain;

    s = idle();
    rst = 1'b1;
    bus.branch_ctrl = 0; bus.idex_mem_r = 0; bus.idex_rd = 0;
    bus.ifid_rs1 = 0; bus.ifid_rs2 = 0; bus.ifid_rs1_use = 0; bus.ifid_rs2_use = 0;
    bus.im_req = 0; bus.im_ready = 0; bus.dm_req = 0; bus.dm_ready = 0; bus.cnt_clr = 0;
    repeat (2) @(posedge clk);

    // Reset cycle
    s = idle(); s.rst = 1;
    apply_stimulus(s);
    @(negedge clk);
    check_output("rst_stall", 32'(bus.stall), 32'h0);
    check_output("rst_flush", 32'(bus.flush), 32'h1f);
    check_output("rst_err",   32'(bus.err),   32'h0);

    // Data-memory wait of three cycles then ready
    s = idle(); s.dm_req = 1;
    repeat (3) apply_stimulus(s);
    s.dm_ready = 1;
    apply_stimulus(s);
    @(negedge clk);
    check_output("dm_ready_stall", 32'(bus.stall), 32'h1f);
    s = idle();
    apply_stimulus(s);
    @(negedge clk);
    check_output("dm_release_stall", 32'(bus.stall), 32'h0);
    check_output("dm_stall_cnt",     32'(bus.stall_cnt), 32'd4);

    // Timeout into the sticky error state
    s = idle(); s.dm_req = 1;
    repeat (1 + TMO) apply_stimulus(s);
    s = idle(); s.dm_ready = 1; s.br = 2'b01;
    repeat (3) apply_stimulus(s);
    @(negedge clk);
    check_output("err_sticky", 32'(bus.err),   32'h1);
    check_output("err_stall",  32'(bus.stall), 32'h1f);
    check_output("err_flush",  32'(bus.flush), 32'h0);
    s = idle(); s.rst = 1;
    apply_stimulus(s);
    s = idle();
    apply_stimulus(s);
    @(negedge clk);
    check_output("err_cleared", 32'(bus.err), 32'h0);

    // Redirect during the wait is deferred until release
    s = idle(); s.rst = 1;
    apply_stimulus(s);
    s = idle(); s.dm_req = 1;
    apply_stimulus(s);
    apply_stimulus(s);
    s.br = 2'b01;
    apply_stimulus(s);
    @(negedge clk);
    check_output("pend_flush_in_wait", 32'(bus.flush), 32'h0);
    s.br = 2'b00;
    apply_stimulus(s);
    s.dm_ready = 1;
    apply_stimulus(s);
    s = idle();
    apply_stimulus(s);
    @(negedge clk);
    check_output("pend_flush", 32'(bus.flush), 32'h06);
    check_output("pend_stall", 32'(bus.stall), 32'h0);
    apply_stimulus(s);
    @(negedge clk);
    check_output("pend_flush_once", 32'(bus.flush), 32'h0);
    check_output("pend_flush_cnt",  32'(bus.flush_cnt), 32'd1);

    // Load-use detection and its qualifiers
    s = idle(); s.mem_r = 1; s.idex_rd = 7; s.rs2 = 7; s.rs2_use = 1; s.rs1 = 3; s.rs1_use = 1;
    apply_stimulus(s);
    @(negedge clk);
    check_output("lu_stall", 32'(bus.stall), 32'h03);
    check_output("lu_flush", 32'(bus.flush), 32'h04);
    s.idex_rd = 0; s.rs2 = 0;
    apply_stimulus(s);
    @(negedge clk);
    check_output("lu_x0_stall", 32'(bus.stall), 32'h0);
    check_output("lu_x0_flush", 32'(bus.flush), 32'h0);
    s.idex_rd = 7; s.rs2 = 7; s.rs2_use = 0;
    apply_stimulus(s);
    @(negedge clk);
    check_output("lu_nouse_stall", 32'(bus.stall), 32'h0);
    check_output("lu_nouse_flush", 32'(bus.flush), 32'h0);

    // Redirect beats load-use in the same cycle
    s.rs2_use = 1; s.br = 2'b10;
    apply_stimulus(s);
    @(negedge clk);
    check_output("br_lu_stall", 32'(bus.stall), 32'h0);
    check_output("br_lu_flush", 32'(bus.flush), 32'h06);

    // Stall counter saturation and clear-over-increment
    s = idle(); s.cnt_clr = 1;
    apply_stimulus(s);
    s = idle(); s.im_req = 1;
    repeat (CNT_MAX + 6) apply_stimulus(s);
    @(negedge clk);
    check_output("sat_stall_cnt", 32'(bus.stall_cnt), 32'(CNT_MAX));
    s.cnt_clr = 1;
    apply_stimulus(s);
    s = idle();
    apply_stimulus(s);
    @(negedge clk);
    check_output("clr_stall_cnt", 32'(bus.stall_cnt), 32'd0);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      s.rst      = ($urandom_range(63) == 0);
      s.br       = ($urandom_range(7) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
      s.mem_r    = 1'($urandom_range(1));
      s.idex_rd  = REG_AW'($urandom_range(3));
      s.rs1      = REG_AW'($urandom_range(3));
      s.rs2      = REG_AW'($urandom_range(3));
      s.rs1_use  = 1'($urandom_range(1));
      s.rs2_use  = 1'($urandom_range(1));
      s.im_req   = 1'($urandom_range(1));
      s.im_ready = 1'($urandom_range(1));
      s.dm_req   = ($urandom_range(3) == 0);
      s.dm_ready = 1'($urandom_range(1));
      s.cnt_clr  = ($urandom_range(31) == 0);
      apply_stimulus(s);
    end

    drain = 0;
    while (exp_q.size() != 0 && drain < 10) begin
      @(negedge clk);
      drain++;
    end
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

Interface
REQ-001 The block SHALL have parameter STAGES, default 5, giving the number of stall/flush slots (index 0 = PC, 1 = IF/ID, 2 = ID/EX, ..., STAGES-1 = MEM/WB); legal range 4..8.
REQ-002 The block SHALL have parameter REG_AW, default 5, giving the register address width.
REQ-003 The block SHALL have parameter BR_FLUSH_DEPTH, default 2, flushing slots 1..BR_FLUSH_DEPTH on redirect; legal range 1..STAGES-2.
REQ-004 The block SHALL have parameter TIMEOUT, default 255, giving the maximum data-memory wait cycles; 0 disables the timeout.
REQ-005 The block SHALL have parameter CNT_W, default 32, giving the performance counter width.
REQ-006 The block SHALL have one clock and a synchronous, active-high reset, with these ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- branch_ctrl  in  2  non-zero = redirect resolved in EX
- idex_mem_r  in  1  ID/EX instruction is a load
- idex_rd  in  REG_AW  load destination
- ifid_rs1, ifid_rs2  in  REG_AW  source registers in decode
- ifid_rs1_use, ifid_rs2_use  in  1  source operand is actually read
- im_req, im_ready  in  1  instruction-memory request / data ready
- dm_req, dm_ready  in  1  EX/MEM data-memory request / done
- cnt_clr  in  1  clear performance counters
- stall  out  STAGES  per-slot hold enable
- flush  out  STAGES  per-slot bubble insert
- err  out  1  sticky data-memory timeout
- stall_cnt  out  CNT_W  cycles with stall[0]=1
- flush_cnt  out  CNT_W  redirect flush events

Function
REQ-010 The FSM SHALL have the states RUN, DM_WAIT and ERR.
REQ-011 In RUN, dm_req=1 with dm_ready=0 SHALL assert stall[all]=1 in the same cycle and move to DM_WAIT next cycle.
REQ-012 In DM_WAIT, stall[all] SHALL be 1 and flush[all] 0 until dm_ready=1; the dm_ready cycle SHALL still stall all slots, and the FSM SHALL return to RUN the next cycle.
REQ-013 A wait counter SHALL clear on entry to DM_WAIT and increment each DM_WAIT cycle; if TIMEOUT!=0 and it reaches TIMEOUT with dm_ready=0, the FSM SHALL go to ERR.
REQ-014 In ERR, stall[all]=1, flush[all]=0 and err=1 SHALL hold until rst.
REQ-015 In RUN, a branch_ctrl!=0 redirect SHALL assert flush[1..BR_FLUSH_DEPTH]=1 with all other flush bits 0 and stall=0, for exactly that cycle.
REQ-016 A redirect seen in DM_WAIT SHALL set pending_redirect; flush SHALL be suppressed while stalled.
REQ-017 On the first RUN cycle, pending_redirect SHALL apply the REQ-015 flush once and clear, even if branch_ctrl is now 0.
REQ-018 A redirect SHALL count once in flush_cnt, whether applied immediately or from pending.
REQ-019 A load-use hazard SHALL be idex_mem_r && idex_rd!=0 && ((ifid_rs1_use && ifid_rs1==idex_rd) || (ifid_rs2_use && ifid_rs2==idex_rd)).
REQ-020 A load-use hazard in RUN SHALL assert stall[0]=stall[1]=1 and flush[2]=1 for one cycle.
REQ-021 Instruction-memory wait (im_req && !im_ready) in RUN SHALL assert stall[0]=1 and flush[1]=1.
REQ-022 Priority (high to low) SHALL be: ERR > DM_WAIT / entry to DM_WAIT > redirect (immediate or pending) > load-use > instruction-memory wait.
REQ-023 A redirect SHALL override load-use and instruction-memory wait, with stall[0]=0 so the PC loads the target.
REQ-024 Outputs SHALL be combinational from the state, pending_redirect and the inputs; there are no further registered outputs.
REQ-025 stall_cnt SHALL increment each cycle with stall[0]=1, and flush_cnt each applied redirect; both SHALL saturate at all-ones.
REQ-026 cnt_clr SHALL zero both counters next cycle and take precedence over increment.

Reset
REQ-030 While rst=1: stall=0, flush=all ones, err=0.
REQ-031 After reset: state=RUN, pending_redirect=0, wait counter=0, stall_cnt=0, flush_cnt=0.
REQ-032 rst asserted mid-DM_WAIT or mid-ERR SHALL abandon the wait, drop any pending redirect and return to RUN.

Verification
REQ-040 Defaults; dm_req=1, dm_ready=0 for 3 cycles then 1 -> stall=5'b11111 for 4 cycles, then 0; stall_cnt=4.
REQ-041 TIMEOUT=4; dm_req=1, dm_ready never -> ERR after 4 wait cycles; err=1 and stall all ones persist until rst.
REQ-042 branch_ctrl=2'b01 in cycle 2 of DM_WAIT, then 0; dm_ready in cycle 4 -> flush=0 during wait; flush=5'b00110 exactly one cycle after release; flush_cnt=1.
REQ-043 idex_mem_r=1, idex_rd=7, ifid_rs2=7, rs2_use=1 -> stall=5'b00011, flush=5'b00100; same with idex_rd=0 or rs2_use=0 -> stall=0, flush=0.
REQ-044 Load-use hazard with branch_ctrl=2'b10 in the same cycle -> stall=0, flush=5'b00110.
REQ-045 stall_cnt preset near all-ones via stalls; cnt_clr together with a stall cycle -> counter reads 0 next cycle; saturation holds at all-ones.
